alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
- Sequential front end for the team's 4-bit combinational ALU. Accepts operation commands over a valid/ready handshake and drives registered operands and function select into the ALU.
- Waits a fixed settle time, then captures the ALU result and flags, and returns them over a valid/ready response channel.
- Keeps a 4-bit accumulator for chained operations, a sticky overflow flag and a completed-operation counter.

Parameters:
- SETTLE, 1: cycles the ALU inputs are held before capture. Legal range is 1..15; 0 is illegal.
- CNT_W, 8: width of the completed-operation counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  block can accept a command
- cmd_op  input  3  ALU function select, passed through unchanged
- cmd_a  input  4  operand A; ignored when cmd_use_acc=1
- cmd_b  input  4  operand B
- cmd_use_acc  input  1  take operand A from the accumulator
- cmd_wb  input  1  write the captured result into the accumulator
- acc_clr  input  1  synchronous clear of the accumulator and the sticky overflow flag
- alu_fnselec  output  3  to ALU, registered
- alu_a  output  4  to ALU, registered
- alu_b  output  4  to ALU, registered
- alu_res  input  4  from ALU
- alu_zero  input  1  from ALU
- alu_overflow  input  1  from ALU
- alu_carry  input  1  from ALU
- rsp_valid  output  1  response present
- rsp_ready  input  1  consumer accepts the response
- rsp_res  output  4  captured result
- rsp_flags  output  3  captured flags, ordered {carry, overflow, zero}
- acc  output  4  accumulator value
- ovf_sticky  output  1  set by any captured overflow
- op_count  output  CNT_W  number of completed response handshakes

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE, settle counter=0.
  - alu_fnselec, alu_a, alu_b, rsp_res, rsp_flags, acc, ovf_sticky and op_count all 0.
  - rsp_valid=0.
  - Reset mid-transaction abandons the operation; no response is produced after reset releases.
- States: IDLE, DRIVE, RESP.
- IDLE:
  - cmd_ready=1, rsp_valid=0.
  - On cmd_valid=1, latch alu_fnselec=cmd_op, alu_b=cmd_b, and alu_a = cmd_use_acc ? acc : cmd_a.
  - Latch the wb bit, load settle counter=SETTLE-1, go to DRIVE.
- DRIVE:
  - cmd_ready=0; ALU inputs stay stable.
  - If counter≠0, decrement it.
  - If counter=0, on the next edge capture rsp_res=alu_res and rsp_flags={alu_carry,alu_overflow,alu_zero}.
  - On that same edge: if alu_overflow=1, set ovf_sticky=1. If wb=1, set acc=alu_res. Go to RESP.
- RESP:
  - rsp_valid=1; rsp_res and rsp_flags are held stable; cmd_ready=0.
  - On rsp_ready=1, go to IDLE and increment op_count. op_count wraps modulo 2^CNT_W.
  - A new command cannot be accepted in the same cycle as the response handshake.
- Latency: accept at edge E0; rsp_valid rises after edge E0+SETTLE. The minimum issue interval is SETTLE+2 cycles.
- ALU input ports (alu_fnselec, alu_a, alu_b) hold their last value outside DRIVE; they are never forced to 0 except by reset.
- acc_clr:
  - Acts in any state. Clears acc and ovf_sticky on the next edge.
  - Has priority over a writeback or sticky-set occurring on the same edge.
  - If acc_clr is high on the same cycle a command with cmd_use_acc=1 is accepted, the latched alu_a is 0.
- Arithmetic: the block performs no arithmetic on data. acc and rsp_res are exactly 4 bits, taken verbatim from alu_res.
- cmd_* inputs are sampled only on the accept edge. Changes to them while in DRIVE or RESP have no effect.

Test Plan:
- Bench uses a behavioural ALU model (add, sub, not, and, or, xor, lt, eq) with SETTLE=1. Command op=000, a=7, b=9, wb=0 -> after 1 cycle rsp_valid=1, rsp_res=0, rsp_flags=3'b101; acc stays 0.
- Accumulate: pulse acc_clr, then issue four commands with op=000, use_acc=1, b=5, wb=1 -> acc steps 5, 10, 15, 4. The fourth response has carry=1. ovf_sticky=1 after the second command (5+5 is signed overflow). A subsequent acc_clr returns acc=0 and ovf_sticky=0.
- Backpressure: hold rsp_ready=0 for 3 cycles after rsp_valid rises -> rsp_res and rsp_flags stay stable and cmd_ready=0 throughout. cmd_valid held high the whole time is accepted only in the cycle after the handshake.
- SETTLE=4: change the model's output during the first 3 DRIVE cycles -> only the value present in the final DRIVE cycle is captured. rsp_valid rises exactly 4 edges after acceptance.
- Assert rst_n=0 during DRIVE and during RESP -> all outputs return to 0 immediately and no rsp_valid follows. op_count preset to 255 (CNT_W=8) with one more handshake -> op_count=0.
- Accept a command with use_acc=1 in the same cycle as acc_clr while acc=9 -> alu_a is driven as 0.

Source files
------------

// File: rtl/alu_op_sequencer_if.sv
// Command, ALU-drive, response and status signals of alu_op_sequencer.
// The sequencer uses the slave modport; the command issuer / ALU side uses master.
interface alu_op_sequencer_if #(
   parameter int unsigned CNT_W = 8
) ();
   logic             cmd_valid;
   logic             cmd_ready;
   logic [2:0]       cmd_op;
   logic [3:0]       cmd_a;
   logic [3:0]       cmd_b;
   logic             cmd_use_acc;
   logic             cmd_wb;
   logic             acc_clr;
   logic [2:0]       alu_fnselec;
   logic [3:0]       alu_a;
   logic [3:0]       alu_b;
   logic [3:0]       alu_res;
   logic             alu_zero;
   logic             alu_overflow;
   logic             alu_carry;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [3:0]       rsp_res;
   logic [2:0]       rsp_flags;
   logic [3:0]       acc;
   logic             ovf_sticky;
   logic [CNT_W-1:0] op_count;

   modport master (
      output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_use_acc, cmd_wb, acc_clr,
      output alu_res, alu_zero, alu_overflow, alu_carry, rsp_ready,
      input  cmd_ready, alu_fnselec, alu_a, alu_b, rsp_valid, rsp_res, rsp_flags,
      input  acc, ovf_sticky, op_count
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_use_acc, cmd_wb, acc_clr,
      input  alu_res, alu_zero, alu_overflow, alu_carry, rsp_ready,
      output cmd_ready, alu_fnselec, alu_a, alu_b, rsp_valid, rsp_res, rsp_flags,
      output acc, ovf_sticky, op_count
   );
endinterface

// File: rtl/alu_op_sequencer.sv
// Sequential front end for the 4-bit combinational ALU: registers operands, waits SETTLE
// cycles, captures result/flags and returns them over a valid/ready response channel.
module alu_op_sequencer #(
   parameter int unsigned SETTLE = 1,
   parameter int unsigned CNT_W  = 8
) (
   input logic               clk,
   input logic               rst_n,
   alu_op_sequencer_if.slave bus_io
);
   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StDrive = 2'd1;
   localparam logic [1:0] StResp  = 2'd2;

   localparam logic [3:0] SettleLoad = 4'(SETTLE - 1);

   logic [1:0]       state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic             wb_q, wb_d;
   logic [2:0]       fn_q, fn_d;
   logic [3:0]       a_q, a_d;
   logic [3:0]       b_q, b_d;
   logic [3:0]       res_q, res_d;
   logic [2:0]       flags_q, flags_d;
   logic [3:0]       acc_q, acc_d;
   logic             ovf_q, ovf_d;
   logic [CNT_W-1:0] op_count_q, op_count_d;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      wb_d       = wb_q;
      fn_d       = fn_q;
      a_d        = a_q;
      b_d        = b_q;
      res_d      = res_q;
      flags_d    = flags_q;
      acc_d      = acc_q;
      ovf_d      = ovf_q;
      op_count_d = op_count_q;
      case (state_q)
         StIdle: begin
            if (bus_io.cmd_valid) begin
               fn_d = bus_io.cmd_op;
               b_d  = bus_io.cmd_b;
               // A same-cycle clear must be visible to an accumulator-sourced operand.
               if (bus_io.cmd_use_acc) a_d = bus_io.acc_clr ? 4'd0 : acc_q;
               else                    a_d = bus_io.cmd_a;
               wb_d    = bus_io.cmd_wb;
               cnt_d   = SettleLoad;
               state_d = StDrive;
            end
         end
         StDrive: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               res_d   = bus_io.alu_res;
               flags_d = {bus_io.alu_carry, bus_io.alu_overflow, bus_io.alu_zero};
               if (bus_io.alu_overflow) ovf_d = 1'b1;
               if (wb_q)                acc_d = bus_io.alu_res;
               state_d = StResp;
            end
         end
         StResp: begin
            if (bus_io.rsp_ready) begin
               op_count_d = op_count_q + CNT_W'(1);
               state_d    = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
      if (bus_io.acc_clr) begin
         acc_d = 4'd0;
         ovf_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         cnt_q      <= 4'd0;
         wb_q       <= 1'b0;
         fn_q       <= 3'd0;
         a_q        <= 4'd0;
         b_q        <= 4'd0;
         res_q      <= 4'd0;
         flags_q    <= 3'd0;
         acc_q      <= 4'd0;
         ovf_q      <= 1'b0;
         op_count_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         wb_q       <= wb_d;
         fn_q       <= fn_d;
         a_q        <= a_d;
         b_q        <= b_d;
         res_q      <= res_d;
         flags_q    <= flags_d;
         acc_q      <= acc_d;
         ovf_q      <= ovf_d;
         op_count_q <= op_count_d;
      end
   end

   assign bus_io.cmd_ready   = (state_q == StIdle);
   assign bus_io.rsp_valid   = (state_q == StResp);
   assign bus_io.alu_fnselec = fn_q;
   assign bus_io.alu_a       = a_q;
   assign bus_io.alu_b       = b_q;
   assign bus_io.rsp_res     = res_q;
   assign bus_io.rsp_flags   = flags_q;
   assign bus_io.acc         = acc_q;
   assign bus_io.ovf_sticky  = ovf_q;
   assign bus_io.op_count    = op_count_q;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench: a SETTLE=1 instance behind a behavioural ALU and a SETTLE=4 instance whose
// ALU outputs are driven directly so capture timing can be observed.
module tb_alu_op_sequencer;
   logic clk;
   logic rst_n;
   int   n_checks = 0;
   int   n_fail   = 0;

   logic [3:0] exp_acc    [4] = '{4'd5, 4'd10, 4'd15, 4'd4};
   logic [2:0] exp_flags  [4] = '{3'b000, 3'b010, 3'b000, 3'b100};
   logic       exp_sticky [4] = '{1'b0, 1'b1, 1'b1, 1'b1};

   alu_op_sequencer_if #(.CNT_W(8)) b1 ();
   alu_op_sequencer_if #(.CNT_W(8)) b4 ();

   alu_op_sequencer #(.SETTLE(1), .CNT_W(8)) dut1 (.clk(clk), .rst_n(rst_n), .bus_io(b1));
   alu_op_sequencer #(.SETTLE(4), .CNT_W(8)) dut4 (.clk(clk), .rst_n(rst_n), .bus_io(b4));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Behavioural ALU: add, sub, not, and, or, xor, signed lt, eq.
   logic [4:0] m_sum;
   always_comb begin
      m_sum           = 5'd0;
      b1.alu_res      = 4'd0;
      b1.alu_carry    = 1'b0;
      b1.alu_overflow = 1'b0;
      case (b1.alu_fnselec)
         3'd0: begin
            m_sum           = {1'b0, b1.alu_a} + {1'b0, b1.alu_b};
            b1.alu_res      = m_sum[3:0];
            b1.alu_carry    = m_sum[4];
            b1.alu_overflow = (b1.alu_a[3] == b1.alu_b[3]) && (m_sum[3] != b1.alu_a[3]);
         end
         3'd1: begin
            m_sum           = {1'b0, b1.alu_a} - {1'b0, b1.alu_b};
            b1.alu_res      = m_sum[3:0];
            b1.alu_carry    = m_sum[4];
            b1.alu_overflow = (b1.alu_a[3] != b1.alu_b[3]) && (m_sum[3] != b1.alu_a[3]);
         end
         3'd2: b1.alu_res = ~b1.alu_a;
         3'd3: b1.alu_res = b1.alu_a & b1.alu_b;
         3'd4: b1.alu_res = b1.alu_a | b1.alu_b;
         3'd5: b1.alu_res = b1.alu_a ^ b1.alu_b;
         3'd6: b1.alu_res = {3'd0, $signed(b1.alu_a) < $signed(b1.alu_b)};
         default: b1.alu_res = {3'd0, b1.alu_a == b1.alu_b};
      endcase
      b1.alu_zero = (b1.alu_res == 4'd0);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send1(input logic [2:0] op, input logic [3:0] a, input logic [3:0] bb,
                        input logic ua, input logic wb, input logic clr);
      check("cmd_ready_idle", b1.cmd_ready, 1);
      b1.cmd_valid   = 1'b1;
      b1.cmd_op      = op;
      b1.cmd_a       = a;
      b1.cmd_b       = bb;
      b1.cmd_use_acc = ua;
      b1.cmd_wb      = wb;
      b1.acc_clr     = clr;
      @(negedge clk);
      b1.cmd_valid = 1'b0;
      b1.acc_clr   = 1'b0;
   endtask

   task automatic wait_rsp1();
      int n = 0;
      while (b1.rsp_valid !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("rsp_latency", n, 1);
   endtask

   task automatic ack1();
      b1.rsp_ready = 1'b1;
      @(negedge clk);
      b1.rsp_ready = 1'b0;
      check("rsp_valid_after_ack", b1.rsp_valid, 0);
   endtask

   task automatic pulse_clr1();
      b1.acc_clr = 1'b1;
      @(negedge clk);
      b1.acc_clr = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      b1.cmd_valid = 0; b1.cmd_op = 0; b1.cmd_a = 0; b1.cmd_b = 0; b1.cmd_use_acc = 0;
      b1.cmd_wb = 0; b1.acc_clr = 0; b1.rsp_ready = 0;
      b4.cmd_valid = 0; b4.cmd_op = 0; b4.cmd_a = 0; b4.cmd_b = 0; b4.cmd_use_acc = 0;
      b4.cmd_wb = 0; b4.acc_clr = 0; b4.rsp_ready = 0;
      b4.alu_res = 0; b4.alu_zero = 0; b4.alu_overflow = 0; b4.alu_carry = 0;
      repeat (2) @(negedge clk);
      check("rst_rsp_valid", b1.rsp_valid, 0);
      check("rst_cmd_ready", b1.cmd_ready, 1);
      check("rst_alu_a", b1.alu_a, 0);
      check("rst_rsp_res", b1.rsp_res, 0);
      check("rst_acc", b1.acc, 0);
      check("rst_ovf", b1.ovf_sticky, 0);
      check("rst_op_count", b1.op_count, 0);
      check("rst4_rsp_valid", b4.rsp_valid, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // 7 + 9 wraps to 0 with carry and zero, no writeback
      send1(3'd0, 4'd7, 4'd9, 1'b0, 1'b0, 1'b0);
      check("t1_alu_fn", b1.alu_fnselec, 0);
      check("t1_alu_a", b1.alu_a, 7);
      check("t1_alu_b", b1.alu_b, 9);
      check("t1_cmd_ready_drive", b1.cmd_ready, 0);
      wait_rsp1();
      check("t1_res", b1.rsp_res, 0);
      check("t1_flags", b1.rsp_flags, 3'b101);
      check("t1_acc", b1.acc, 0);
      check("t1_cmd_ready_resp", b1.cmd_ready, 0);
      ack1();
      check("t1_op_count", b1.op_count, 1);

      // 3 - 5 = 0xE with borrow
      send1(3'd1, 4'd3, 4'd5, 1'b0, 1'b0, 1'b0);
      wait_rsp1();
      check("sub_res", b1.rsp_res, 4'hE);
      check("sub_flags", b1.rsp_flags, 3'b100);
      ack1();

      pulse_clr1();
      for (int i = 0; i < 4; i++) begin
         send1(3'd0, 4'd0, 4'd5, 1'b1, 1'b1, 1'b0);
         wait_rsp1();
         check("accum_res", b1.rsp_res, exp_acc[i]);
         check("accum_acc", b1.acc, exp_acc[i]);
         check("accum_flags", b1.rsp_flags, exp_flags[i]);
         check("accum_sticky", b1.ovf_sticky, exp_sticky[i]);
         ack1();
      end
      check("accum_op_count", b1.op_count, 6);
      pulse_clr1();
      check("clr_acc", b1.acc, 0);
      check("clr_sticky", b1.ovf_sticky, 0);

      // Backpressure with cmd_valid held high throughout
      b1.cmd_valid = 1'b1; b1.cmd_op = 3'd3; b1.cmd_a = 4'hC; b1.cmd_b = 4'hA;
      b1.cmd_use_acc = 1'b0; b1.cmd_wb = 1'b0;
      @(negedge clk);
      check("bp_cmd_ready_drive", b1.cmd_ready, 0);
      @(negedge clk);
      check("bp_rsp_valid", b1.rsp_valid, 1);
      b1.cmd_a = 4'd3;
      for (int i = 0; i < 3; i++) begin
         check("bp_res_stable", b1.rsp_res, 8);
         check("bp_flags_stable", b1.rsp_flags, 0);
         check("bp_cmd_ready", b1.cmd_ready, 0);
         check("bp_rsp_valid_held", b1.rsp_valid, 1);
         @(negedge clk);
      end
      b1.rsp_ready = 1'b1;
      check("bp_cmd_ready_hs", b1.cmd_ready, 0);
      @(negedge clk);
      b1.rsp_ready = 1'b0;
      check("bp_idle_cmd_ready", b1.cmd_ready, 1);
      check("bp_op_count", b1.op_count, 7);
      @(negedge clk);
      b1.cmd_valid = 1'b0;
      check("bp_second_accept", b1.cmd_ready, 0);
      check("bp_second_alu_a", b1.alu_a, 3);
      wait_rsp1();
      check("bp_second_res", b1.rsp_res, 2);
      ack1();

      // Load acc=9, then accept use_acc together with acc_clr
      send1(3'd0, 4'd9, 4'd0, 1'b0, 1'b1, 1'b0);
      wait_rsp1();
      ack1();
      check("acc_nine", b1.acc, 9);
      send1(3'd0, 4'hF, 4'd1, 1'b1, 1'b0, 1'b1);
      check("clr_use_acc_alu_a", b1.alu_a, 0);
      check("clr_use_acc_acc", b1.acc, 0);
      wait_rsp1();
      check("clr_use_acc_res", b1.rsp_res, 1);
      ack1();
      check("pre_rst_op_count", b1.op_count, 10);

      // SETTLE=4: only the last DRIVE-cycle ALU value is captured
      check("s4_cmd_ready", b4.cmd_ready, 1);
      b4.alu_res = 4'd1; b4.alu_carry = 1; b4.alu_overflow = 1; b4.alu_zero = 1;
      b4.cmd_valid = 1'b1; b4.cmd_op = 3'd2; b4.cmd_a = 4'd5; b4.cmd_b = 4'd6;
      b4.cmd_use_acc = 1'b0; b4.cmd_wb = 1'b1;
      @(negedge clk);
      b4.cmd_valid = 1'b0;
      check("s4_alu_fn", b4.alu_fnselec, 2);
      check("s4_alu_a", b4.alu_a, 5);
      check("s4_alu_b", b4.alu_b, 6);
      for (int i = 0; i < 3; i++) begin
         check("s4_rsp_valid_early", b4.rsp_valid, 0);
         b4.alu_res = 4'(i + 2);
         @(negedge clk);
      end
      check("s4_rsp_valid_last_drive", b4.rsp_valid, 0);
      b4.alu_res = 4'hA; b4.alu_carry = 1; b4.alu_overflow = 0; b4.alu_zero = 0;
      @(negedge clk);
      check("s4_rsp_valid", b4.rsp_valid, 1);
      check("s4_res", b4.rsp_res, 4'hA);
      check("s4_flags", b4.rsp_flags, 3'b100);
      check("s4_acc", b4.acc, 4'hA);
      check("s4_sticky", b4.ovf_sticky, 0);
      b4.alu_res = 4'hF;
      @(negedge clk);
      check("s4_res_held", b4.rsp_res, 4'hA);
      b4.rsp_ready = 1'b1;
      @(negedge clk);
      b4.rsp_ready = 1'b0;
      check("s4_op_count", b4.op_count, 1);
      check("s4_rsp_valid_after", b4.rsp_valid, 0);

      // Reset during DRIVE
      send1(3'd4, 4'd3, 4'd4, 1'b0, 1'b1, 1'b0);
      #1 rst_n = 1'b0;
      #1;
      check("rd_rsp_valid", b1.rsp_valid, 0);
      check("rd_alu_a", b1.alu_a, 0);
      check("rd_alu_b", b1.alu_b, 0);
      check("rd_alu_fn", b1.alu_fnselec, 0);
      check("rd_op_count", b1.op_count, 0);
      check("rd_s4_acc", b4.acc, 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rd_no_rsp", b1.rsp_valid, 0);
      end
      check("rd_acc_no_wb", b1.acc, 0);

      // Reset during RESP
      send1(3'd0, 4'd3, 4'd4, 1'b0, 1'b0, 1'b0);
      wait_rsp1();
      check("rr_res_before", b1.rsp_res, 7);
      #1 rst_n = 1'b0;
      #1;
      check("rr_rsp_valid", b1.rsp_valid, 0);
      check("rr_rsp_res", b1.rsp_res, 0);
      check("rr_rsp_flags", b1.rsp_flags, 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rr_no_rsp", b1.rsp_valid, 0);
         check("rr_cmd_ready", b1.cmd_ready, 1);
      end

      // op_count wrap at 2^8
      for (int i = 0; i < 255; i++) begin
         send1(3'd0, 4'd1, 4'd1, 1'b0, 1'b0, 1'b0);
         wait_rsp1();
         ack1();
      end
      check("wrap_255", b1.op_count, 255);
      send1(3'd0, 4'd1, 4'd1, 1'b0, 1'b0, 1'b0);
      wait_rsp1();
      ack1();
      check("wrap_0", b1.op_count, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
